// File: rtl/prog_loader.sv
// Boot-time program loader: parses a byte stream (length, N little-endian words,
// XOR checksum) into instruction memory and releases the core only on a good load.
module prog_loader #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              run, xfer, len_bad, last_word, restart;
  logic [31:0]       len_ext;
  logic [ADDR_W:0]   n_q, widx_inc, wc_q;
  logic [ADDR_W-1:0] widx_q, addr_q;
  logic [1:0]        bidx_q;
  logic [23:0]       word_q;
  logic [31:0]       wdata_q;
  logic [7:0]        csum_q;

  // Reset asserts asynchronously but releases through two flops, so the FSM
  // cannot move before the second edge after rst goes high.
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], 1'b1};

  assign run       = sync_q[1];
  assign xfer      = byte_valid && byte_ready;
  assign len_ext   = {24'd0, byte_in};
  assign len_bad   = (byte_in == 8'd0) || (len_ext > CAP);
  assign widx_inc  = {1'b0, widx_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (widx_inc == n_q);
  assign restart   = run && start && (state_q inside {S_IDLE, S_DONE, S_ERR});

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (restart) state_d = S_LEN;
      S_LEN:   if (xfer) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA:  if (xfer && bidx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state_q)
      S_LEN, S_DATA, S_CSUM: byte_ready = 1'b1;
      S_WRITE: mem_we = 1'b1;
      S_DONE:  begin done = 1'b1; cpu_hold = 1'b0; end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Address/data are captured with the 4th byte so they are stable through
  // the WRITE cycle and keep their value afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q     <= '0;
      wc_q    <= '0;
      widx_q  <= '0;
      addr_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
    end else if (restart) begin
      wc_q   <= '0;
      widx_q <= '0;
      bidx_q <= '0;
      csum_q <= '0;
    end else begin
      case (state_q)
        S_LEN: if (xfer && !len_bad) n_q <= len_ext[ADDR_W:0];
        S_DATA: if (xfer) begin
          csum_q <= csum_q ^ byte_in;
          bidx_q <= bidx_q + 2'd1;
          case (bidx_q)
            2'd0:    word_q[7:0]   <= byte_in;
            2'd1:    word_q[15:8]  <= byte_in;
            2'd2:    word_q[23:16] <= byte_in;
            default: begin
              addr_q  <= widx_q;
              wdata_q <= {byte_in, word_q};
            end
          endcase
        end
        S_WRITE: begin
          wc_q <= wc_q + {{ADDR_W{1'b0}}, 1'b1};
          if (!last_word) widx_q <= widx_inc[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a stream-level model predicts writes and the
// final status, and a per-cycle monitor checks every memory write against it.
module tb_prog_loader;
  localparam int AW = 4;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0]    byte_in = 8'd0;
  logic          byte_ready, mem_we, cpu_hold, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int            n_chk = 0, n_err = 0, cyc = 0, t_first = 0, t_end = 0;
  wr_t           exp_q[$];
  wr_t           cw;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;
  bit            exp_done, exp_err;
  int            exp_wc, exp_n;
  logic [7:0]    s[$];
  logic [7:0]    cs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Every write must match the model's next expected write; between writes
  // the address/data outputs hold the last written (or reset) value.
  always @(negedge clk) begin
    if (!rst) begin
      last_addr = '0;
      last_data = '0;
    end
    if (mem_we) begin
      chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_we: addr %0h data %0h with no write expected", mem_addr, mem_wdata);
      end else begin
        cw = exp_q.pop_front();
        chk("wr_addr", {28'd0, mem_addr}, {28'd0, cw.addr});
        chk("wr_data", mem_wdata, cw.data);
        last_addr = cw.addr;
        last_data = cw.data;
      end
    end else begin
      chk("hold_addr", {28'd0, mem_addr}, {28'd0, last_addr});
      chk("hold_data", mem_wdata, last_data);
    end
  end

  // Stream-level model: length byte, N little-endian words, XOR of data bytes.
  task automatic model_load(input logic [7:0] b[$]);
    logic [7:0]  x;
    logic [31:0] w;
    int          n;
    n = b[0]; x = 8'd0; exp_wc = 0; exp_done = 0; exp_err = 0; exp_n = n;
    if (n == 0 || n > (1 << AW)) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {b[4*i+4], b[4*i+3], b[4*i+2], b[4*i+1]};
      x = x ^ b[4*i+1] ^ b[4*i+2] ^ b[4*i+3] ^ b[4*i+4];
      exp_q.push_back('{addr: i[AW-1:0], data: w});
      exp_wc++;
    end
    if (b.size() > 4*n+1 && b[4*n+1] == x) exp_done = 1;
    else exp_err = 1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input int cnt, input bit gaps);
    bit acc;
    int budget;
    for (int k = 0; k < cnt; k++) begin
      byte_in = b[k];
      budget = 0;
      acc = 0;
      do begin
        byte_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        @(negedge clk);
        acc = byte_valid && byte_ready;
        if (acc && k == 0) t_first = cyc;
        @(posedge clk); #1;
        budget++;
      end while (!acc && budget < 60);
      if (!acc) begin
        n_chk++; n_err++;
        $display("FAIL byte_timeout: byte %0d not accepted within 60 cycles", k);
        byte_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_end();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || error) begin
        t_end = cyc;
        return;
      end
    end
    n_chk++; n_err++;
    $display("FAIL end_timeout: neither done nor error within 40 cycles");
  endtask

  task automatic do_load(input logic [7:0] b[$], input bit gaps, input string tag);
    model_load(b);
    pulse_start();
    send(b, b.size(), gaps);
    byte_valid = 1'b0;
    wait_end();
    #1;
    chk({tag, "_done"},  {31'd0, done},     {31'd0, exp_done});
    chk({tag, "_error"}, {31'd0, error},    {31'd0, exp_err});
    chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk({tag, "_wc"},    {27'd0, word_count}, exp_wc);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
    if (!gaps && exp_done) chk({tag, "_latency"}, t_end - t_first, 5*exp_n + 2);
  endtask

  task automatic build(input int n, input int seed, input logic [7:0] cs_flip);
    s.delete();
    s.push_back(n[7:0]);
    cs = 8'd0;
    for (int i = 0; i < 4*n; i++) begin
      s.push_back(8'((i * 37 + seed) ^ (i >> 2)));
      cs = cs ^ s[i+1];
    end
    s.push_back(cs ^ cs_flip);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we",    {31'd0, mem_we},     32'd0);
    chk("rst_hold",  {31'd0, cpu_hold},   32'd1);
    chk("rst_done",  {31'd0, done},       32'd0);
    chk("rst_error", {31'd0, error},      32'd0);
    chk("rst_wc",    {27'd0, word_count}, 32'd0);

    // start held over the first edge after release must be ignored
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sync_release_ready", {31'd0, byte_ready}, 32'd0);

    // single word: 78^56^34^12 = 08 is the XOR of the data bytes
    s = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    model_load(s);
    chk("model_word0", exp_q[0].data, 32'h12345678);
    chk("model_done1", {31'd0, exp_done}, 32'd1);
    exp_q.delete();
    do_load(s, 0, "one_word");
    chk("one_word_latency_lit", t_end - t_first, 32'd7);

    build(16, 5, 8'h00);
    do_load(s, 0, "full16");
    chk("full16_wc_lit", {27'd0, word_count}, 32'd16);

    build(2, 9, 8'h01);
    do_load(s, 0, "bad_csum");
    chk("bad_csum_err_lit", {31'd0, error}, 32'd1);
    pulse_start();
    chk("restart_error", {31'd0, error}, 32'd0);
    chk("restart_wc", {27'd0, word_count}, 32'd0);
    chk("restart_ready", {31'd0, byte_ready}, 32'd1);

    s = '{8'h00};
    do_load(s, 0, "len0");
    s = '{8'h11};
    do_load(s, 0, "len17");
    chk("len17_err_lit", {31'd0, error}, 32'd1);

    build(3, 77, 8'h00);
    do_load(s, 0, "w3_b2b");
    do_load(s, 1, "w3_gaps");

    // reset while the third byte of word 1 is being offered
    build(3, 21, 8'h00);
    model_load(s);
    pulse_start();
    send(s, 7, 0);
    byte_in = s[7];
    byte_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we",    {31'd0, mem_we},     32'd0);
    chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("mid_rst_hold",  {31'd0, cpu_hold},   32'd1);
    chk("mid_rst_addr",  {28'd0, mem_addr},   32'd0);
    chk("mid_rst_data",  mem_wdata,           32'd0);
    chk("mid_rst_wc",    {27'd0, word_count}, 32'd0);
    chk("mid_rst_done",  {30'd0, done, error}, 32'd0);
    exp_q.delete();
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, byte_ready}, 32'd0);
    build(3, 21, 8'h00);
    do_load(s, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
